// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0..T3) with bounded memory wait, then decode/execute
// (T4..T7) for ALU, mul/div, nop and halt instructions. All outputs are a Moore decode.
module control_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        Mem_ready,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic        Zin_low,
    output logic        Zin_high,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [3:0]  operation,
    output logic        Run,
    output logic        Fault
);

    localparam int unsigned CntW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              fault_q, fault_d;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_md, is_halt;
    logic [3:0] alu_code;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    always_comb begin
        is_alu   = 1'b0;
        is_md    = 1'b0;
        is_halt  = 1'b0;
        alu_code = 4'b0000;
        case (opcode)
            5'b00011: begin is_alu = 1'b1; alu_code = 4'b0001; end
            5'b00100: begin is_alu = 1'b1; alu_code = 4'b0010; end
            5'b00101: begin is_alu = 1'b1; alu_code = 4'b1000; end
            5'b00110: begin is_alu = 1'b1; alu_code = 4'b1001; end
            5'b00111: begin is_alu = 1'b1; alu_code = 4'b0011; end
            5'b01000: begin is_alu = 1'b1; alu_code = 4'b0100; end
            5'b01001: begin is_alu = 1'b1; alu_code = 4'b0101; end
            5'b01010: begin is_alu = 1'b1; alu_code = 4'b0110; end
            5'b01110: begin is_md  = 1'b1; alu_code = 4'b1010; end
            5'b01111: begin is_md  = 1'b1; alu_code = 4'b1011; end
            5'b11011: is_halt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_q <= StRst;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Wait counter idles at zero outside T2, so every entry to T2 starts a fresh count.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        fault_d = fault_q;
        unique case (state_q)
            StRst: state_d = StT0;
            StT0:  state_d = StT1;
            StT1:  state_d = StT2;
            StT2: begin
                if (Mem_ready) begin
                    state_d = StT3;
                end else if (cnt_q == CntW'(MEM_TIMEOUT - 1)) begin
                    state_d = StHalt;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StT3: state_d = StT4;
            StT4: begin
                if (is_alu || is_md) state_d = StT5;
                else if (is_halt)    state_d = StHalt;
                else                 state_d = Stop ? StHalt : StT0;
            end
            StT5: state_d = StT6;
            StT6: begin
                if (is_md) state_d = StT7;
                else       state_d = Stop ? StHalt : StT0;
            end
            StT7:   state_d = Stop ? StHalt : StT0;
            StHalt: state_d = StHalt;
            default: state_d = StRst;
        endcase
    end

    always_comb begin
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        MDRout    = 1'b0;
        MARin     = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        Zin_low   = 1'b0;
        Zin_high  = 1'b0;
        Rin       = 16'h0000;
        Rout      = 16'h0000;
        operation = 4'b0000;
        Run       = (state_q != StRst) && (state_q != StHalt);
        Fault     = fault_q;
        unique case (state_q)
            StT0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin_low = 1'b1;
            end
            StT1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
            end
            StT2: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            StT3: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StT4: begin
                if (is_alu || is_md) begin
                    Rout = 16'(1) << rb;
                    Yin  = 1'b1;
                end
            end
            StT5: begin
                if (is_alu || is_md) begin
                    Rout      = 16'(1) << rc;
                    operation = alu_code;
                    Zin_low   = 1'b1;
                    Zin_high  = is_md;
                end
            end
            StT6: begin
                Zlowout = 1'b1;
                if (is_md) LOin = 1'b1;
                else       Rin  = 16'(1) << ra;
            end
            StT7: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer: cycle-by-cycle output vectors plus
// hand-written sequences for memory timeout, halt hold, asynchronous clear and Stop.
module tb_control_sequencer;

    logic        Clock, clear, Mem_ready, Stop;
    logic [31:0] IR;
    logic        PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, HIin, LOin;
    logic        IncPC, Read, Zin_low, Zin_high, Run, Fault;
    logic [15:0] Rin, Rout;
    logic [3:0]  operation;

    control_sequencer #(.MEM_TIMEOUT(15)) dut (
        .Clock(Clock), .clear(clear), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin),
        .LOin(LOin), .IncPC(IncPC), .Read(Read), .Zin_low(Zin_low), .Zin_high(Zin_high),
        .Rin(Rin), .Rout(Rout), .operation(operation), .Run(Run), .Fault(Fault)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    localparam logic [16:0] B_PCOUT = 17'd1 << 16;
    localparam logic [16:0] B_ZLO   = 17'd1 << 15;
    localparam logic [16:0] B_ZHI   = 17'd1 << 14;
    localparam logic [16:0] B_MDROUT= 17'd1 << 13;
    localparam logic [16:0] B_MARIN = 17'd1 << 12;
    localparam logic [16:0] B_PCIN  = 17'd1 << 11;
    localparam logic [16:0] B_MDRIN = 17'd1 << 10;
    localparam logic [16:0] B_IRIN  = 17'd1 << 9;
    localparam logic [16:0] B_YIN   = 17'd1 << 8;
    localparam logic [16:0] B_HIIN  = 17'd1 << 7;
    localparam logic [16:0] B_LOIN  = 17'd1 << 6;
    localparam logic [16:0] B_INCPC = 17'd1 << 5;
    localparam logic [16:0] B_READ  = 17'd1 << 4;
    localparam logic [16:0] B_ZINL  = 17'd1 << 3;
    localparam logic [16:0] B_ZINH  = 17'd1 << 2;
    localparam logic [16:0] B_RUN   = 17'd1 << 1;
    localparam logic [16:0] B_FAULT = 17'd1;

    localparam logic [16:0] S_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZINL | B_RUN;
    localparam logic [16:0] S_T1 = B_ZLO | B_PCIN | B_READ | B_RUN;
    localparam logic [16:0] S_T2 = B_READ | B_MDRIN | B_RUN;
    localparam logic [16:0] S_T3 = B_MDROUT | B_IRIN | B_RUN;

    logic [16:0] act_s;
    assign act_s = {PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, HIin,
                    LOin, IncPC, Read, Zin_low, Zin_high, Run, Fault};

    typedef struct {
        logic [31:0] ir;
        logic        mr;
        logic        stop;
        logic [16:0] s;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [3:0]  op;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mkv(logic [31:0] ir, logic mr, logic stop, logic [16:0] s,
                                 logic [15:0] rin, logic [15:0] rout, logic [3:0] op);
        vec_t v;
        v.ir = ir; v.mr = mr; v.stop = stop; v.s = s; v.rin = rin; v.rout = rout; v.op = op;
        return v;
    endfunction

    function automatic logic [31:0] mk_ir(logic [4:0] opc, int ra, int rb, int rc);
        return {opc, 4'(ra), 4'(rb), 4'(rc), 15'd0};
    endfunction

    function automatic logic [15:0] oh(int n);
        return 16'(1) << n;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(string nm, logic [16:0] s, logic [15:0] rin, logic [15:0] rout,
                         logic [3:0] op);
        n_cmp++;
        if (act_s !== s || Rin !== rin || Rout !== rout || operation !== op) begin
            n_err++;
            $display("FAIL %s: got strobes=%h Rin=%h Rout=%h op=%b, want strobes=%h Rin=%h Rout=%h op=%b",
                     nm, act_s, Rin, Rout, operation, s, rin, rout, op);
        end
    endtask

    task automatic check_int(string nm, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    // Fetch: T0, T1, `waits` T2 cycles without Mem_ready, one with it, T3.
    task automatic push_fetch(logic [31:0] ir, int waits);
        tbl.push_back(mkv(ir, 1'b0, 1'b0, S_T0, 16'h0, 16'h0, 4'b0));
        tbl.push_back(mkv(ir, 1'b0, 1'b0, S_T1, 16'h0, 16'h0, 4'b0));
        for (int i = 0; i < waits; i++)
            tbl.push_back(mkv(ir, 1'b0, 1'b0, S_T2, 16'h0, 16'h0, 4'b0));
        tbl.push_back(mkv(ir, 1'b1, 1'b0, S_T2, 16'h0, 16'h0, 4'b0));
        tbl.push_back(mkv(ir, 1'b0, 1'b0, S_T3, 16'h0, 16'h0, 4'b0));
    endtask

    task automatic run_tbl(string tag);
        foreach (tbl[i]) begin
            IR = tbl[i].ir; Mem_ready = tbl[i].mr; Stop = tbl[i].stop;
            #1;
            check($sformatf("%s[%0d]", tag, i), tbl[i].s, tbl[i].rin, tbl[i].rout, tbl[i].op);
            tick();
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        clear = 1'b1; Stop = 1'b0; Mem_ready = 1'b0;
        tick();
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ir_and, ir_mul, ir_sub, ir_und, ir_ror, ir_hlt, ir_nop;
        int          n_t2;
        ir_and = 32'h28918000;
        ir_mul = 32'h70918000;
        ir_sub = mk_ir(5'b00100, 5, 6, 7);
        ir_und = mk_ir(5'b11111, 1, 2, 3);
        ir_ror = mk_ir(5'b01001, 15, 0, 14);
        ir_hlt = 32'hD8000000;
        ir_nop = mk_ir(5'b11010, 4, 4, 4);
        clear = 1'b1; IR = 32'h0; Mem_ready = 1'b0; Stop = 1'b0;
        #1;
        check("async_reset", 17'h0, 16'h0, 16'h0, 4'b0);

        // Main instruction stream: and, mul, sub with 3 wait cycles, undefined, ror + Stop.
        do_reset();
        tbl.push_back(mkv(ir_and, 1'b1, 1'b0, 17'h0, 16'h0, 16'h0, 4'b0));
        push_fetch(ir_and, 0);
        tbl.push_back(mkv(ir_and, 1'b0, 1'b0, B_YIN | B_RUN, 16'h0, 16'h0004, 4'b0));
        tbl.push_back(mkv(ir_and, 1'b0, 1'b0, B_ZINL | B_RUN, 16'h0, 16'h0008, 4'b1000));
        tbl.push_back(mkv(ir_and, 1'b0, 1'b0, B_ZLO | B_RUN, 16'h0002, 16'h0, 4'b0));
        push_fetch(ir_mul, 0);
        tbl.push_back(mkv(ir_mul, 1'b0, 1'b0, B_YIN | B_RUN, 16'h0, 16'h0004, 4'b0));
        tbl.push_back(mkv(ir_mul, 1'b0, 1'b0, B_ZINL | B_ZINH | B_RUN, 16'h0, 16'h0008,
                          4'b1010));
        tbl.push_back(mkv(ir_mul, 1'b0, 1'b0, B_ZLO | B_LOIN | B_RUN, 16'h0, 16'h0, 4'b0));
        tbl.push_back(mkv(ir_mul, 1'b0, 1'b0, B_ZHI | B_HIIN | B_RUN, 16'h0, 16'h0, 4'b0));
        push_fetch(ir_sub, 3);
        tbl.push_back(mkv(ir_sub, 1'b0, 1'b0, B_YIN | B_RUN, 16'h0, oh(6), 4'b0));
        tbl.push_back(mkv(ir_sub, 1'b0, 1'b0, B_ZINL | B_RUN, 16'h0, oh(7), 4'b0010));
        tbl.push_back(mkv(ir_sub, 1'b0, 1'b0, B_ZLO | B_RUN, oh(5), 16'h0, 4'b0));
        push_fetch(ir_und, 0);
        tbl.push_back(mkv(ir_und, 1'b0, 1'b0, B_RUN, 16'h0, 16'h0, 4'b0));
        push_fetch(ir_ror, 1);
        tbl.push_back(mkv(ir_ror, 1'b0, 1'b0, B_YIN | B_RUN, 16'h0, oh(0), 4'b0));
        tbl.push_back(mkv(ir_ror, 1'b0, 1'b0, B_ZINL | B_RUN, 16'h0, oh(14), 4'b0101));
        tbl.push_back(mkv(ir_ror, 1'b0, 1'b1, B_ZLO | B_RUN, oh(15), 16'h0, 4'b0));
        tbl.push_back(mkv(ir_ror, 1'b1, 1'b0, 17'h0, 16'h0, 16'h0, 4'b0));
        tbl.push_back(mkv(ir_ror, 1'b0, 1'b0, 17'h0, 16'h0, 16'h0, 4'b0));
        run_tbl("stream");

        // Halt opcode: HALT after T4 and held regardless of inputs.
        do_reset();
        tbl.push_back(mkv(ir_hlt, 1'b1, 1'b0, 17'h0, 16'h0, 16'h0, 4'b0));
        push_fetch(ir_hlt, 0);
        tbl.push_back(mkv(ir_hlt, 1'b0, 1'b0, B_RUN, 16'h0, 16'h0, 4'b0));
        run_tbl("halt_op");
        for (int i = 0; i < 20; i++) begin
            Mem_ready = 1'(i); Stop = 1'(i >> 1);
            #1;
            check($sformatf("halt_hold[%0d]", i), 17'h0, 16'h0, 16'h0, 4'b0);
            tick();
        end

        // Memory timeout: exactly 15 T2 cycles then HALT with Fault, sticky until clear.
        do_reset();
        tbl.push_back(mkv(ir_and, 1'b0, 1'b0, 17'h0, 16'h0, 16'h0, 4'b0));
        tbl.push_back(mkv(ir_and, 1'b0, 1'b0, S_T0, 16'h0, 16'h0, 4'b0));
        tbl.push_back(mkv(ir_and, 1'b0, 1'b0, S_T1, 16'h0, 16'h0, 4'b0));
        run_tbl("timeout_fetch");
        n_t2 = 0;
        while (n_t2 < 40 && act_s == S_T2 && Rin == 16'h0 && Rout == 16'h0) begin
            n_t2++;
            tick();
        end
        check_int("timeout_t2_cycles", n_t2, 15);
        check("timeout_halt", B_FAULT, 16'h0, 16'h0, 4'b0);
        Mem_ready = 1'b1;
        tick();
        tick();
        check("fault_sticky", B_FAULT, 16'h0, 16'h0, 4'b0);
        #2 clear = 1'b1;
        #1 check("fault_cleared", 17'h0, 16'h0, 16'h0, 4'b0);

        // Asynchronous clear in T5, then T0 one cycle after release.
        do_reset();
        tbl.push_back(mkv(ir_and, 1'b1, 1'b0, 17'h0, 16'h0, 16'h0, 4'b0));
        push_fetch(ir_and, 0);
        tbl.push_back(mkv(ir_and, 1'b0, 1'b0, B_YIN | B_RUN, 16'h0, 16'h0004, 4'b0));
        run_tbl("clr_pre");
        check("clr_in_t5", B_ZINL | B_RUN, 16'h0, 16'h0008, 4'b1000);
        #2 clear = 1'b1;
        #1 check("clr_async", 17'h0, 16'h0, 16'h0, 4'b0);
        tick();
        check("clr_held", 17'h0, 16'h0, 16'h0, 4'b0);
        clear = 1'b0;
        #1 check("clr_rst", 17'h0, 16'h0, 16'h0, 4'b0);
        tick();
        check("clr_to_t0", S_T0, 16'h0, 16'h0, 4'b0);

        // Nop with Stop at T4 goes to HALT.
        do_reset();
        tbl.push_back(mkv(ir_nop, 1'b1, 1'b0, 17'h0, 16'h0, 16'h0, 4'b0));
        push_fetch(ir_nop, 0);
        tbl.push_back(mkv(ir_nop, 1'b0, 1'b1, B_RUN, 16'h0, 16'h0, 4'b0));
        tbl.push_back(mkv(ir_nop, 1'b0, 1'b0, 17'h0, 16'h0, 16'h0, 4'b0));
        run_tbl("nop_stop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
